// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - serial multiply-accumulate neuron with saturated fixed-point output
module neuron_mac #(
  parameter int DWIDTH = 16,
  parameter int IWIDTH = 64,
  parameter int FRAC   = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DWIDTH-1:0]          bias,
  input  logic [DWIDTH-1:0]          k,
  input  logic [DWIDTH-1:0]          w,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [$clog2(IWIDTH)-1:0]  term_idx,
  output logic                       busy,
  output logic                       out_valid,
  output logic [DWIDTH-1:0]          result
);

  localparam int IDXW = $clog2(IWIDTH);
  localparam int PW   = 2 * DWIDTH;
  localparam int ACCW = PW + IDXW;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(IWIDTH - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN =
    {{(ACCW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [DWIDTH-1:0]        result_q, result_d;

  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     prod_sh;
  logic signed [ACCW-1:0]   term_ext;
  logic signed [ACCW-1:0]   bias_ext;
  logic signed [ACCW-1:0]   acc_sum;

  // The accumulator is wide enough that only the final value needs clamping.
  function automatic logic [DWIDTH-1:0] sat(input logic signed [ACCW-1:0] a);
    if (a > SAT_MAX)
      return {1'b0, {(DWIDTH-1){1'b1}}};
    else if (a < SAT_MIN)
      return {1'b1, {(DWIDTH-1){1'b0}}};
    else
      return a[DWIDTH-1:0];
  endfunction

  // Full-precision product, rescaled by an arithmetic shift (rounds toward -inf).
  assign prod     = $signed(k) * $signed(w);
  assign prod_sh  = prod >>> FRAC;
  assign term_ext = {{(ACCW-PW){prod_sh[PW-1]}}, prod_sh};
  assign bias_ext = {{(ACCW-DWIDTH){bias[DWIDTH-1]}}, bias};
  assign acc_sum  = acc_q + term_ext;

  // Next-state logic: load bias on start, accumulate accepted terms, publish once.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          idx_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d = acc_sum;
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            result_d = sat(acc_sum);
            state_d  = S_OUT;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign term_idx  = idx_q;
  assign result    = result_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - scoreboard bench for neuron_mac against an arithmetic reference
module tb_neuron_mac;

  localparam int DW = 16;
  localparam int NI = 64;
  localparam int FR = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] bias;
  logic [DW-1:0] k;
  logic [DW-1:0] w;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    term_idx;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] result;

  neuron_mac #(.DWIDTH(DW), .IWIDTH(NI), .FRAC(FR)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .k         (k),
    .w         (w),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .term_idx  (term_idx),
    .busy      (busy),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int n_eval = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] k_arr [NI];
  logic [DW-1:0] w_arr [NI];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: exact rational sum of floor(k*w / 2^FRAC) plus bias, clamped to 16 bits.
  function automatic logic [DW-1:0] ref_eval(input logic [DW-1:0] b);
    longint s;
    longint p;
    s = longint'($signed(b));
    for (int i = 0; i < NI; i++) begin
      p = longint'($signed(k_arr[i])) * longint'($signed(w_arr[i]));
      s = s + (p >>> FR);
    end
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[DW-1:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (out_valid) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(result), 32'hFFFF_FFFF);
      end else begin
        chk("result", 32'(result), 32'(exp_q.pop_front()));
      end
    end
  end

  // One evaluation; gap_pct sets the chance of an idle cycle before each term.
  task automatic run_eval(input logic [DW-1:0] b, input int gap_pct, input bit noise);
    int gaps;
    exp_q.push_back(ref_eval(b));
    n_eval++;
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
    bias  = 16'($urandom);
    chk("in_ready_after_start", 32'(in_ready), 32'd1);
    for (int i = 0; i < NI; i++) begin
      gaps = 0;
      while (gaps < 4 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        k = 16'($urandom);
        w = 16'($urandom);
        start = noise;
        tick();
        start = 1'b0;
        gaps++;
      end
      chk("term_idx", 32'(term_idx), 32'(i));
      in_valid = 1'b1;
      k = k_arr[i];
      w = w_arr[i];
      start = noise && (i == 10);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("out_valid_timing", 32'(out_valid), 32'd1);
    chk("busy_in_out", 32'(busy), 32'd1);
    chk("in_ready_in_out", 32'(in_ready), 32'd0);
    chk("term_idx_wrap", 32'(term_idx), 32'd0);
    start = noise;
    bias  = 16'h1234;
    tick();
    start = 1'b0;
    chk("busy_after_out", 32'(busy), 32'd0);
    chk("out_valid_single", 32'(out_valid), 32'd0);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < NI; i++) begin
      unique case (mode)
        0: begin k_arr[i] = (i == 5) ? 16'h0200 : 16'h0000; w_arr[i] = (i == 5) ? 16'hFE00 : 16'($urandom); end
        1: begin k_arr[i] = 16'h0200; w_arr[i] = 16'h0200; end
        2: begin k_arr[i] = 16'h0200; w_arr[i] = 16'h8000; end
        3: begin k_arr[i] = (i % 2 == 0) ? 16'h0200 : 16'h0000; w_arr[i] = 16'h0040; end
        4: begin k_arr[i] = $urandom_range(1) ? 16'h0200 : 16'h0000; w_arr[i] = 16'($urandom); end
        5: begin k_arr[i] = 16'($urandom); w_arr[i] = 16'($urandom); end
        default: begin k_arr[i] = 16'h0000; w_arr[i] = 16'($urandom); end
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] b;
    rst = 1'b1; start = 1'b0; bias = '0; k = '0; w = '0; in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_term_idx", 32'(term_idx), 32'd0);

    fill(0); run_eval(16'h0100, 0, 1'b0);
    fill(1); run_eval(16'h0000, 0, 1'b0);
    fill(2); run_eval(16'h0000, 0, 1'b0);
    fill(3); run_eval(16'hFC00, 0, 1'b0);
    run_eval(16'hFC00, 50, 1'b0);
    run_eval(16'hFC00, 30, 1'b1);

    // Rest in IDLE with in_valid asserted; nothing should happen.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; k = 16'($urandom); w = 16'($urandom);
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    for (int r = 0; r < 6; r++) begin
      fill(r % 2 == 0 ? 4 : 5);
      run_eval(16'($urandom), int'($urandom_range(60)), r[0]);
    end

    // Reset after 30 accepted terms: partial sum discarded, no output.
    fill(5);
    start = 1'b1; bias = 16'h0777;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; k = k_arr[i]; w = w_arr[i];
      tick();
    end
    chk("midrst_term_idx_pre", 32'(term_idx), 32'd30);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_term_idx", 32'(term_idx), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    tick();

    fill(6);
    b = 16'($urandom);
    run_eval(b, 20, 1'b0);
    run_eval(16'h8001, 0, 1'b0);

    tick(); tick(); tick();
    chk("pending_expected", 32'(exp_q.size()), 32'd0);
    chk("out_pulse_count", 32'(n_out), 32'(n_eval));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
